mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Sits directly downstream of the I- and D-cache controllers; owns the single main-memory port.
//  Grants one cache at a time and locks the grant for a whole block burst (writeback or refill).
//  Owns each requester's word counter and generates per-word memory addresses.
//  Returns the per-word ready strobe that drives the caches' burst state machines.
// PARAMETERS
//  ADDR_W   32  byte address width
//  DATA_W   32  word width
//  BLK_WORDS 4  words per cache block (power of 2); CNT_W = $clog2(BLK_WORDS) = 2
// PORTS
//  clk          in   1       clock
//  reset        in   1       asynchronous, active-high
//  d_re         in   1       D-cache refill request (MemRE)
//  d_we         in   1       D-cache writeback request (HWriteM)
//  d_rst_cnt    in   1       D-cache ResetCounter: clear d_cnt
//  d_blk_addr   in   ADDR_W  D-cache block address; low CNT_W+2 bits ignored
//  d_wdata      in   DATA_W  D-cache writeback word for d_cnt
//  d_cnt        out  CNT_W   D-cache word counter (controller's Counter)
//  d_bus_ready  out  1       D-cache word accepted/returned this cycle (BusReady)
//  i_re         in   1       I-cache refill request
//  i_rst_cnt    in   1       clear i_cnt
//  i_blk_addr   in   ADDR_W  I-cache block address
//  i_cnt        out  CNT_W   I-cache word counter
//  i_bus_ready  out  1       I-cache word returned this cycle
//  rdata        out  DATA_W  mem_rdata passthrough, valid with *_bus_ready
//  mem_addr     out  ADDR_W  {blk_addr[ADDR_W-1:CNT_W+2], cnt, 2'b00} of granted side
//  mem_re       out  1       memory read strobe
//  mem_we       out  1       memory write strobe
//  mem_wdata    out  DATA_W  d_wdata when D write granted, else 0
//  mem_ready    in   1       memory completes current word this cycle
// BEHAVIOUR
//  States: IDLE, D_BURST, I_BURST. Reset -> IDLE, d_cnt=i_cnt=0, last_grant=I, all outputs 0.
//  IDLE: D request (d_re|d_we) only -> D_BURST; i_re only -> I_BURST; both -> side != last_grant.
//   Grant takes effect next cycle; no memory strobes in IDLE (1-cycle arbitration latency).
//  D_BURST: mem_we=d_we, mem_re=d_re&~d_we (write wins if both high); d_bus_ready=mem_ready.
//  I_BURST: mem_re=1; i_bus_ready=mem_ready.
//  Counter: granted side's cnt increments on mem_ready, wraps BLK_WORDS-1 -> 0.
//   mem_ready with cnt==BLK_WORDS-1 ends burst: -> IDLE, last_grant=that side.
//  Requester drops request mid-burst: abort -> IDLE next cycle, its cnt cleared, no strobes.
//  *_rst_cnt clears that counter and overrides increment; ungranted side's counter holds.
//  Writeback->refill: D drops d_we, raises d_re after burst; it re-arbitrates from IDLE, so a
//   waiting I-cache gets the bus first (last_grant=D).
//  mem_addr/mem_wdata stable while strobe high and mem_ready low.
//  *_bus_ready never asserts for an ungranted side; both never high in same cycle.
//  Reset mid-burst: immediate IDLE, strobes drop asynchronously.
// STRUCTURE
//  Shared package mem_bus_pkg: typedef enum logic [1:0] {IDLE,D_BURST,I_BURST} bus_state_t;
//   localparams BLK_WORDS, CNT_W.
//  One sub-module: block_word_counter (clk, reset, clr, inc, cnt, last) instantiated twice.
// TESTING
//  D refill alone, d_blk_addr=0x1000, mem_ready every cycle -> mem_addr 0x1000,1004,1008,100C;
//   d_cnt 0..3; d_bus_ready 4 cycles; IDLE after word 3.
//  D writeback then refill, d_blk_addr=0x2040 -> 4 mem_we words then 4 mem_re words;
//   IDLE cycle between bursts.
//  d_re and i_re raised same cycle after reset -> D granted first (last_grant=I);
//   I burst follows immediately.
//  I burst, mem_ready every 3rd cycle, D requests mid-burst -> I completes all 4 words;
//   d_bus_ready stays 0; D granted after.
//  d_re dropped after 2 words -> IDLE next cycle, d_cnt=0, mem_re=0.
//  reset pulsed during D_BURST at d_cnt=2 -> all strobes 0, counters 0, fresh request starts at word 0.

Source files
------------

// File: rtl/mem_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bus_pkg
//  Purpose  : Shared types and block geometry for the memory bus arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package mem_bus_pkg;

    localparam int BLK_WORDS = 4;
    localparam int CNT_W     = $clog2(BLK_WORDS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        D_BURST = 2'd1,
        I_BURST = 2'd2
    } bus_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bus_arbiter_if
//  Purpose  : Cache-side and memory-side signals of the memory bus arbiter.
//  Revision : 1.0  initial release
// ============================================================================
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    import mem_bus_pkg::*;

    logic              d_re;
    logic              d_we;
    logic              d_rst_cnt;
    logic [ADDR_W-1:0] d_blk_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [CNT_W-1:0]  d_cnt;
    logic              d_bus_ready;

    logic              i_re;
    logic              i_rst_cnt;
    logic [ADDR_W-1:0] i_blk_addr;
    logic [CNT_W-1:0]  i_cnt;
    logic              i_bus_ready;

    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    // The arbiter owns the memory port, so it is the bus master.
    modport master (
        input  d_re, d_we, d_rst_cnt, d_blk_addr, d_wdata,
        input  i_re, i_rst_cnt, i_blk_addr,
        input  mem_ready, mem_rdata,
        output d_cnt, d_bus_ready, i_cnt, i_bus_ready,
        output rdata, mem_addr, mem_re, mem_we, mem_wdata
    );

    modport slave (
        output d_re, d_we, d_rst_cnt, d_blk_addr, d_wdata,
        output i_re, i_rst_cnt, i_blk_addr,
        output mem_ready, mem_rdata,
        input  d_cnt, d_bus_ready, i_cnt, i_bus_ready,
        input  rdata, mem_addr, mem_re, mem_we, mem_wdata
    );

endinterface
`default_nettype wire

// File: rtl/mem_bus_arbiter_counter.sv
`default_nettype none
// ============================================================================
//  Module   : block_word_counter
//  Purpose  : Word index within a cache block; wraps at BLK_WORDS-1.
//  Revision : 1.0  initial release
// ============================================================================
module block_word_counter
    import mem_bus_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    logic [CNT_W-1:0] r_cnt;

    // Clear has priority over increment; BLK_WORDS is a power of two so
    // the natural overflow provides the wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt  = r_cnt;
    assign last = (r_cnt == CNT_W'(BLK_WORDS - 1));

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bus_arbiter
//  Purpose  : Grants the main-memory port to the I- or D-cache for whole
//             block bursts and generates per-word addresses and ready strobes.
//  Revision : 1.0  initial release
// ============================================================================
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    mem_bus_arbiter_if.master bus
);

    localparam logic [ADDR_W-1:0] C_OFS_MASK = ADDR_W'(BLK_WORDS * 4 - 1);

    bus_state_t        r_state;
    bus_state_t        w_state_nxt;
    logic              r_last_d;
    logic              w_last_d_nxt;

    logic              w_d_req;
    logic              w_d_clr;
    logic              w_i_clr;
    logic              w_d_last;
    logic              w_i_last;
    logic [CNT_W-1:0]  w_d_cnt;
    logic [CNT_W-1:0]  w_i_cnt;
    logic [ADDR_W-1:0] w_d_addr;
    logic [ADDR_W-1:0] w_i_addr;

    logic              w_mem_re;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_d_rdy;
    logic              w_i_rdy;

    assign w_d_req = bus.d_re | bus.d_we;

    // A requester withdrawing mid-burst aborts it and rewinds its counter.
    assign w_d_clr = bus.d_rst_cnt | ((r_state == D_BURST) & ~w_d_req);
    assign w_i_clr = bus.i_rst_cnt | ((r_state == I_BURST) & ~bus.i_re);

    block_word_counter u_d_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (w_d_clr),
        .inc   (w_d_rdy),
        .cnt   (w_d_cnt),
        .last  (w_d_last)
    );

    block_word_counter u_i_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (w_i_clr),
        .inc   (w_i_rdy),
        .cnt   (w_i_cnt),
        .last  (w_i_last)
    );

    assign w_d_addr = (bus.d_blk_addr & ~C_OFS_MASK) | ADDR_W'({w_d_cnt, 2'b00});
    assign w_i_addr = (bus.i_blk_addr & ~C_OFS_MASK) | ADDR_W'({w_i_cnt, 2'b00});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_last_d <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_last_d <= w_last_d_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_last_d_nxt = r_last_d;
        w_mem_re     = 1'b0;
        w_mem_we     = 1'b0;
        w_addr       = '0;
        w_wdata      = '0;
        w_d_rdy      = 1'b0;
        w_i_rdy      = 1'b0;

        case (r_state)
            IDLE: begin
                // On contention the side that did not own the last burst wins.
                if (w_d_req && (!bus.i_re || !r_last_d)) begin
                    w_state_nxt = D_BURST;
                end else if (bus.i_re) begin
                    w_state_nxt = I_BURST;
                end
            end

            D_BURST: begin
                w_addr = w_d_addr;
                if (!w_d_req) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_mem_we = bus.d_we;
                    w_mem_re = bus.d_re & ~bus.d_we;
                    w_d_rdy  = bus.mem_ready;
                    if (bus.d_we) begin
                        w_wdata = bus.d_wdata;
                    end
                    if (bus.mem_ready && w_d_last) begin
                        w_state_nxt  = IDLE;
                        w_last_d_nxt = 1'b1;
                    end
                end
            end

            I_BURST: begin
                w_addr = w_i_addr;
                if (!bus.i_re) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_mem_re = 1'b1;
                    w_i_rdy  = bus.mem_ready;
                    if (bus.mem_ready && w_i_last) begin
                        w_state_nxt  = IDLE;
                        w_last_d_nxt = 1'b0;
                    end
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.d_cnt       = w_d_cnt;
    assign bus.i_cnt       = w_i_cnt;
    assign bus.d_bus_ready = w_d_rdy;
    assign bus.i_bus_ready = w_i_rdy;
    assign bus.mem_re      = w_mem_re;
    assign bus.mem_we      = w_mem_we;
    assign bus.mem_addr    = w_addr;
    assign bus.mem_wdata   = w_wdata;
    assign bus.rdata       = bus.mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_bus_arbiter
//  Purpose  : Directed scenarios plus random cache/memory traffic against a
//             burst-level reference model of the memory bus arbiter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_bus_arbiter;
    import mem_bus_pkg::*;

    logic clk = 1'b0;
    logic reset;

    mem_bus_arbiter_if bus ();

    mem_bus_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: who owns the bus (0 none, 1 D, 2 I), word counters,
    // which side finished the last burst, and burst-completion pulses.
    int m_owner;
    int m_dcnt;
    int m_icnt;
    bit m_last_d;
    bit m_d_done;
    bit m_i_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner  = 0;
        m_dcnt   = 0;
        m_icnt   = 0;
        m_last_d = 1'b0;
        m_d_done = 1'b0;
        m_i_done = 1'b0;
    endtask

    task automatic model_check();
        logic        dreq;
        logic        e_we, e_re, e_dbr, e_ibr;
        logic [31:0] e_addr, e_wdata, mask;
        mask  = BLK_WORDS * 4 - 1;
        dreq  = bus.d_re | bus.d_we;
        e_we  = 1'b0; e_re = 1'b0; e_dbr = 1'b0; e_ibr = 1'b0;
        e_addr = 32'h0; e_wdata = 32'h0;
        if (m_owner == 1) begin
            e_addr = (bus.d_blk_addr & ~mask) + 32'(m_dcnt * 4);
            if (dreq) begin
                e_we    = bus.d_we;
                e_re    = bus.d_re & ~bus.d_we;
                e_dbr   = bus.mem_ready;
                e_wdata = bus.d_we ? bus.d_wdata : 32'h0;
            end
        end else if (m_owner == 2) begin
            e_addr = (bus.i_blk_addr & ~mask) + 32'(m_icnt * 4);
            if (bus.i_re) begin
                e_re  = 1'b1;
                e_ibr = bus.mem_ready;
            end
        end
        chk("mem_we",      32'(bus.mem_we),      32'(e_we));
        chk("mem_re",      32'(bus.mem_re),      32'(e_re));
        chk("d_bus_ready", 32'(bus.d_bus_ready), 32'(e_dbr));
        chk("i_bus_ready", 32'(bus.i_bus_ready), 32'(e_ibr));
        chk("mem_addr",    bus.mem_addr,         e_addr);
        chk("mem_wdata",   bus.mem_wdata,        e_wdata);
        chk("d_cnt",       32'(bus.d_cnt),       32'(m_dcnt));
        chk("i_cnt",       32'(bus.i_cnt),       32'(m_icnt));
        chk("ready_excl",  32'(bus.d_bus_ready & bus.i_bus_ready), 32'h0);
        if (e_dbr || e_ibr) chk("rdata", bus.rdata, bus.mem_rdata);
    endtask

    task automatic model_update();
        bit dreq, rd, ri;
        int n;
        m_d_done = 1'b0;
        m_i_done = 1'b0;
        if (reset) begin
            model_reset();
            return;
        end
        dreq = bus.d_re | bus.d_we;
        rd   = (m_owner == 1) && dreq && bus.mem_ready;
        ri   = (m_owner == 2) && bus.i_re && bus.mem_ready;
        n    = m_owner;
        case (m_owner)
            0: if (dreq && (!bus.i_re || !m_last_d)) n = 1; else if (bus.i_re) n = 2;
            1: if (!dreq) n = 0;
               else if (rd && m_dcnt == BLK_WORDS - 1) begin n = 0; m_last_d = 1'b1; m_d_done = 1'b1; end
            2: if (!bus.i_re) n = 0;
               else if (ri && m_icnt == BLK_WORDS - 1) begin n = 0; m_last_d = 1'b0; m_i_done = 1'b1; end
            default: n = 0;
        endcase
        if (bus.d_rst_cnt || (m_owner == 1 && !dreq)) m_dcnt = 0;
        else if (rd) m_dcnt = (m_dcnt + 1) % BLK_WORDS;
        if (bus.i_rst_cnt || (m_owner == 2 && !bus.i_re)) m_icnt = 0;
        else if (ri) m_icnt = (m_icnt + 1) % BLK_WORDS;
        m_owner = n;
    endtask

    task automatic at_neg();
        @(negedge clk);
        model_check();
    endtask

    task automatic at_pos();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic clear_inputs();
        bus.d_re = 0; bus.d_we = 0; bus.d_rst_cnt = 0; bus.d_blk_addr = 0; bus.d_wdata = 0;
        bus.i_re = 0; bus.i_rst_cnt = 0; bus.i_blk_addr = 0;
        bus.mem_ready = 0; bus.mem_rdata = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        repeat (2) begin at_neg(); at_pos(); end
        reset = 1'b0;
    endtask

    int d_act, i_act, cyc, iw;
    logic exp_d, exp_i, exp_w;

    initial begin
        clear_inputs();
        reset = 1'b1;
        model_reset();
        #2;
        chk("rst_mem_re", 32'(bus.mem_re), 32'h0);
        chk("rst_d_cnt",  32'(bus.d_cnt),  32'h0);
        at_pos();
        do_reset();

        // D refill alone at 0x1000
        bus.d_blk_addr = 32'h1000; bus.d_re = 1; bus.mem_ready = 1; bus.mem_rdata = 32'hA5A5_0000;
        at_neg(); chk("s1_arb_re", 32'(bus.mem_re), 32'h0); at_pos();
        for (int w = 0; w < 4; w++) begin
            bus.mem_rdata = 32'hA5A5_0000 + 32'(w);
            at_neg();
            chk("s1_addr", bus.mem_addr, 32'h1000 + 32'(4 * w));
            chk("s1_cnt",  32'(bus.d_cnt), 32'(w));
            chk("s1_rdy",  32'(bus.d_bus_ready), 32'h1);
            at_pos();
        end
        bus.d_re = 0;
        at_neg(); chk("s1_idle", 32'(bus.mem_re), 32'h0); at_pos();

        // D writeback then refill at 0x2040
        bus.d_blk_addr = 32'h2040; bus.d_we = 1;
        for (int c = 0; c < 10; c++) begin
            bus.d_wdata = $urandom;
            exp_w = (c >= 1 && c <= 4);
            exp_d = (c >= 6);
            at_neg();
            chk("s2_we", 32'(bus.mem_we), 32'(exp_w));
            chk("s2_re", 32'(bus.mem_re), 32'(exp_d));
            if (exp_w || exp_d) chk("s2_addr", bus.mem_addr, 32'h2040 + 32'(4 * ((c - 1) % 5)));
            at_pos();
            if (c == 4) begin bus.d_we = 0; bus.d_re = 1; end
        end
        bus.d_re = 0;
        at_neg(); at_pos();

        // Simultaneous requests after reset: D first, then I
        do_reset();
        bus.d_blk_addr = 32'h1100; bus.i_blk_addr = 32'h8800;
        bus.d_re = 1; bus.i_re = 1; bus.mem_ready = 1;
        for (int c = 0; c < 10; c++) begin
            exp_d = (c >= 1 && c <= 4);
            exp_i = (c >= 6);
            at_neg();
            chk("s3_dgrant", 32'(bus.d_bus_ready), 32'(exp_d));
            chk("s3_igrant", 32'(bus.i_bus_ready), 32'(exp_i));
            at_pos();
            if (c == 4) bus.d_re = 0;
        end
        bus.i_re = 0;
        at_neg(); at_pos();

        // I burst with slow memory, D requesting mid-burst
        bus.i_blk_addr = 32'h3000; bus.i_re = 1;
        cyc = 0; iw = 0;
        do begin
            bus.mem_ready = (cyc % 3 == 2);
            if (cyc == 4) begin bus.d_re = 1; bus.d_blk_addr = 32'h4000; end
            at_neg();
            if (bus.i_bus_ready) iw++;
            if (cyc >= 4) chk("s4_d_blocked", 32'(bus.d_bus_ready), 32'h0);
            at_pos();
            cyc++;
        end while (!m_i_done && cyc < 60);
        chk("s4_iwords", 32'(iw), 32'h4);
        bus.i_re = 0; bus.mem_ready = 1;
        at_neg(); chk("s4_idle", 32'(bus.mem_re), 32'h0); at_pos();
        at_neg(); chk("s4_dgrant", 32'(bus.mem_re), 32'h1); at_pos();
        cyc = 0;
        while (!m_d_done && cyc < 10) begin at_neg(); at_pos(); cyc++; end
        chk("s4_dburst_done", 32'(m_d_done), 32'h1);
        bus.d_re = 0;
        at_neg(); at_pos();

        // D aborts after 2 words
        bus.d_blk_addr = 32'h5000; bus.d_re = 1; bus.mem_ready = 1;
        repeat (3) begin at_neg(); at_pos(); end
        bus.d_re = 0;
        at_neg();
        chk("s5_nostrobe", 32'(bus.mem_re), 32'h0);
        chk("s5_cnt_hold", 32'(bus.d_cnt), 32'h2);
        at_pos();
        at_neg();
        chk("s5_cnt_clr", 32'(bus.d_cnt), 32'h0);
        at_pos();

        // Reset mid-burst at d_cnt=2
        bus.d_blk_addr = 32'h6000; bus.d_re = 1;
        repeat (3) begin at_neg(); at_pos(); end
        chk("s6_cnt2", 32'(bus.d_cnt), 32'h2);
        chk("s6_re_on", 32'(bus.mem_re), 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("s6_async_re",   32'(bus.mem_re), 32'h0);
        chk("s6_async_cnt",  32'(bus.d_cnt), 32'h0);
        chk("s6_async_addr", bus.mem_addr, 32'h0);
        model_reset();
        at_neg(); at_pos();
        reset = 1'b0;
        at_neg(); at_pos();
        at_neg();
        chk("s6_restart_cnt",  32'(bus.d_cnt), 32'h0);
        chk("s6_restart_addr", bus.mem_addr, 32'h6000);
        at_pos();
        bus.d_re = 0;
        at_neg(); at_pos();

        // Random traffic
        d_act = 0; i_act = 0;
        for (int k = 0; k < 1500; k++) begin
            if (m_d_done) d_act = (d_act == 2 && ($urandom % 2 == 1)) ? 1 : 0;
            else if (d_act == 0) begin
                if ($urandom % 4 == 0) begin
                    d_act = ($urandom % 2 == 1) ? 1 : 2;
                    bus.d_blk_addr = $urandom;
                end
            end else if ($urandom % 60 == 0) d_act = 0;
            if (m_i_done) i_act = 0;
            else if (i_act == 0) begin
                if ($urandom % 4 == 0) begin i_act = 1; bus.i_blk_addr = $urandom; end
            end else if ($urandom % 60 == 0) i_act = 0;
            bus.d_we      = (d_act == 2);
            bus.d_re      = (d_act == 1) || (d_act == 2 && ($urandom % 4 == 0));
            bus.i_re      = (i_act == 1);
            bus.d_rst_cnt = ($urandom % 40 == 0);
            bus.i_rst_cnt = ($urandom % 40 == 0);
            bus.d_wdata   = $urandom;
            bus.mem_ready = ($urandom % 2 == 1);
            bus.mem_rdata = $urandom;
            at_neg();
            at_pos();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
